// File: rtl/us_tx_ctrl_if.sv
// Command/status bundle between the command decoder and the ultrasonic TX controller.
// The master side issues decoder command levels; the slave side returns drive and status outputs.
interface us_tx_ctrl_if #(
  parameter int unsigned AMOUNT_WIDTH = 8
);
  logic                    on;
  logic                    off;
  logic                    increase;
  logic                    decrease;
  logic                    send;
  logic                    receive;
  logic                    valid;
  logic [AMOUNT_WIDTH-1:0] amount;
  logic [AMOUNT_WIDTH-1:0] dac_level;
  logic                    powered;
  logic                    tx_p;
  logic                    tx_n;
  logic                    rx_enable;
  logic                    busy;
  logic                    burst_done;
  logic                    cmd_drop;

  modport master (
    output on, off, increase, decrease, send, receive, valid, amount,
    input  dac_level, powered, tx_p, tx_n, rx_enable, busy, burst_done, cmd_drop
  );

  modport slave (
    input  on, off, increase, decrease, send, receive, valid, amount,
    output dac_level, powered, tx_p, tx_n, rx_enable, busy, burst_done, cmd_drop
  );
endinterface

// File: rtl/us_tx_ctrl.sv
// Ultrasonic transmit controller: edge-detects held decoder commands, slews the DAC drive
// level toward a target, and sequences TX burst / blanking / echo-listen windows.
module us_tx_ctrl #(
  parameter int unsigned AMOUNT_WIDTH  = 8,
  parameter int unsigned HALF_PERIOD   = 1250,
  parameter int unsigned BURST_CYCLES  = 8,
  parameter int unsigned BLANK_CYCLES  = 2000,
  parameter int unsigned LISTEN_CYCLES = 200000,
  parameter int unsigned RAMP_DIV      = 16
) (
  input  logic        clk,
  input  logic        rst,
  us_tx_ctrl_if.slave bus
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_TX     = 2'd1;
  localparam logic [1:0] ST_BLANK  = 2'd2;
  localparam logic [1:0] ST_LISTEN = 2'd3;

  localparam int unsigned CNT_MAX =
    (HALF_PERIOD > BLANK_CYCLES)
      ? ((HALF_PERIOD > LISTEN_CYCLES) ? HALF_PERIOD : LISTEN_CYCLES)
      : ((BLANK_CYCLES > LISTEN_CYCLES) ? BLANK_CYCLES : LISTEN_CYCLES);
  localparam int unsigned CNT_W  = $clog2(CNT_MAX + 1);
  localparam int unsigned HALF_W = $clog2(2 * BURST_CYCLES + 1);
  localparam int unsigned PRE_W  = $clog2(RAMP_DIV + 1);

  localparam logic [CNT_W-1:0]  HP_LAST   = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0]  BL_LAST   = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LS_LAST   = CNT_W'(LISTEN_CYCLES - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * BURST_CYCLES - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(RAMP_DIV - 1);

  logic [4:0]              r_prev;
  logic                    r_powered;
  logic [AMOUNT_WIDTH-1:0] r_target;
  logic [AMOUNT_WIDTH-1:0] r_dac;
  logic [PRE_W-1:0]        r_pre;
  logic [1:0]              r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [HALF_W-1:0]       r_half;
  logic                    r_rx_req;
  logic                    r_tx_p;
  logic                    r_tx_n;
  logic                    r_done;
  logic                    r_drop;

  logic [4:0]              w_cmd;
  logic [4:0]              w_evt;
  logic                    w_on_evt, w_off_evt, w_inc_evt, w_dec_evt, w_send_evt;
  logic                    w_inc_ok, w_dec_ok, w_send_ok, w_drop;
  logic [AMOUNT_WIDTH:0]   w_inc_sum;
  logic [AMOUNT_WIDTH-1:0] w_inc_sat;
  logic [AMOUNT_WIDTH-1:0] w_dec_val;

  assign w_cmd      = {bus.on, bus.off, bus.increase, bus.decrease, bus.send};
  assign w_evt      = w_cmd & ~r_prev & {5{bus.valid}};
  assign w_on_evt   = w_evt[4];
  assign w_off_evt  = w_evt[3];
  assign w_inc_evt  = w_evt[2];
  assign w_dec_evt  = w_evt[1];
  assign w_send_evt = w_evt[0];

  // Simultaneous increase and decrease cancel each other and count as one rejection.
  assign w_inc_ok  = w_inc_evt & ~w_dec_evt & r_powered;
  assign w_dec_ok  = w_dec_evt & ~w_inc_evt & r_powered;
  assign w_send_ok = w_send_evt & r_powered & (r_state == ST_IDLE);
  assign w_drop    = ((w_inc_evt | w_dec_evt) & (~r_powered | (w_inc_evt & w_dec_evt)))
                   | (w_send_evt & ~w_send_ok);

  assign w_inc_sum = {1'b0, r_target} + {1'b0, bus.amount};
  assign w_inc_sat = w_inc_sum[AMOUNT_WIDTH] ? '1 : w_inc_sum[AMOUNT_WIDTH-1:0];
  assign w_dec_val = (bus.amount > r_target) ? '0 : r_target - bus.amount;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev    <= '0;
      r_powered <= 1'b0;
      r_target  <= '0;
      r_dac     <= '0;
      r_pre     <= '0;
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_half    <= '0;
      r_rx_req  <= 1'b0;
      r_tx_p    <= 1'b0;
      r_tx_n    <= 1'b0;
      r_done    <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_prev <= w_cmd;
      r_drop <= w_drop;
      r_done <= 1'b0;

      if (r_powered) begin
        r_pre <= (r_pre == PRE_LAST) ? '0 : r_pre + 1'b1;
        if ((r_pre == PRE_LAST) && (r_dac != r_target))
          r_dac <= (r_dac < r_target) ? r_dac + 1'b1 : r_dac - 1'b1;
      end else begin
        r_pre <= '0;
      end

      if (w_inc_ok)
        r_target <= w_inc_sat;
      else if (w_dec_ok)
        r_target <= w_dec_val;

      if (w_on_evt) begin
        r_powered <= 1'b1;
        r_target  <= bus.amount;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_send_ok) begin
            r_state  <= ST_TX;
            r_cnt    <= '0;
            r_half   <= '0;
            r_tx_p   <= 1'b1;
            r_tx_n   <= 1'b0;
            r_rx_req <= bus.receive;
          end
        end
        ST_TX: begin
          if (r_cnt == HP_LAST) begin
            r_cnt <= '0;
            if (r_half == HALF_LAST) begin
              r_state <= ST_BLANK;
              r_tx_p  <= 1'b0;
              r_tx_n  <= 1'b0;
            end else begin
              r_half <= r_half + 1'b1;
              r_tx_p <= ~r_tx_p;
              r_tx_n <= ~r_tx_n;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_BLANK: begin
          if (r_cnt == BL_LAST) begin
            r_cnt <= '0;
            if (r_rx_req) begin
              r_state <= ST_LISTEN;
            end else begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_LISTEN: begin
          if (r_cnt == LS_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Power-off overrides everything above: drive drops at once and the burst is abandoned.
      if (w_off_evt) begin
        r_powered <= 1'b0;
        r_target  <= '0;
        r_dac     <= '0;
        r_pre     <= '0;
        r_state   <= ST_IDLE;
        r_cnt     <= '0;
        r_half    <= '0;
        r_tx_p    <= 1'b0;
        r_tx_n    <= 1'b0;
        r_done    <= 1'b0;
      end
    end
  end

  assign bus.dac_level  = r_dac;
  assign bus.powered    = r_powered;
  assign bus.tx_p       = r_tx_p;
  assign bus.tx_n       = r_tx_n;
  assign bus.rx_enable  = (r_state == ST_LISTEN);
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.burst_done = r_done;
  assign bus.cmd_drop   = r_drop;
endmodule

// File: tb/tb_us_tx_ctrl.sv
// Self-checking bench for us_tx_ctrl: a time-since-burst-start reference model runs beside
// the DUT while directed and randomized scenarios compare outputs every cycle.
module tb_us_tx_ctrl;
  localparam int AW   = 8;
  localparam int HP   = 2;
  localparam int BC   = 3;
  localparam int BL   = 4;
  localparam int LS   = 5;
  localparam int RD   = 1;
  localparam int TXL  = 2 * BC * HP;
  localparam int MAXV = (1 << AW) - 1;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  us_tx_ctrl_if #(.AMOUNT_WIDTH(AW)) bus_if ();

  us_tx_ctrl #(
    .AMOUNT_WIDTH (AW),
    .HALF_PERIOD  (HP),
    .BURST_CYCLES (BC),
    .BLANK_CYCLES (BL),
    .LISTEN_CYCLES(LS),
    .RAMP_DIV     (RD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  // Reference model: burst outputs derived from elapsed cycles since the accepted send.
  int m_pow = 0, m_tgt = 0, m_dac = 0, m_pc = 0, m_act = 0, m_t = 0, m_rxreq = 0;
  int m_done = 0, m_drop = 0;
  bit [4:0] m_prev = '0;

  always @(posedge clk) begin : model
    int pow, tgt, dac, pc, act, t, rxreq, done, drop, amt;
    bit e_on, e_off, e_inc, e_dec, e_send;
    pow = m_pow; tgt = m_tgt; dac = m_dac; pc = m_pc; act = m_act; t = m_t;
    rxreq = m_rxreq; done = 0; drop = 0; amt = int'(bus_if.amount);
    if (rst) begin
      pow = 0; tgt = 0; dac = 0; pc = 0; act = 0; t = 0; rxreq = 0;
      m_prev <= '0;
    end else begin
      e_on   = bus_if.on       && !m_prev[4] && bus_if.valid;
      e_off  = bus_if.off      && !m_prev[3] && bus_if.valid;
      e_inc  = bus_if.increase && !m_prev[2] && bus_if.valid;
      e_dec  = bus_if.decrease && !m_prev[1] && bus_if.valid;
      e_send = bus_if.send     && !m_prev[0] && bus_if.valid;
      m_prev <= {bus_if.on, bus_if.off, bus_if.increase, bus_if.decrease, bus_if.send};
      if (m_pow != 0) begin
        if ((m_pc % RD) == RD - 1 && m_dac != m_tgt) dac = (m_dac < m_tgt) ? m_dac + 1 : m_dac - 1;
        pc = m_pc + 1;
      end else pc = 0;
      if (m_act != 0) begin
        t = m_t + 1;
        if ((m_rxreq == 0 && t == TXL + BL) || t == TXL + BL + LS) begin act = 0; done = 1; end
      end
      if (e_inc && e_dec) drop = 1;
      else if (e_inc) begin
        if (m_pow != 0) tgt = (m_tgt + amt > MAXV) ? MAXV : m_tgt + amt; else drop = 1;
      end else if (e_dec) begin
        if (m_pow != 0) tgt = (m_tgt - amt < 0) ? 0 : m_tgt - amt; else drop = 1;
      end
      if (e_send) begin
        if (m_pow != 0 && m_act == 0) begin act = 1; t = 0; rxreq = int'(bus_if.receive); end
        else drop = 1;
      end
      if (e_on) begin pow = 1; tgt = amt; end
      if (e_off) begin pow = 0; tgt = 0; dac = 0; pc = 0; act = 0; done = 0; end
    end
    m_pow <= pow; m_tgt <= tgt; m_dac <= dac; m_pc <= pc; m_act <= act; m_t <= t;
    m_rxreq <= rxreq; m_done <= done; m_drop <= drop;
  end

  function automatic logic [14:0] exp_vec();
    bit tx_on;
    tx_on = (m_act != 0) && (m_t < TXL);
    return {8'(m_dac), m_pow != 0, tx_on && ((m_t / HP) % 2 == 0), tx_on && ((m_t / HP) % 2 == 1),
            (m_act != 0) && (m_t >= TXL + BL), m_act != 0, m_done != 0, m_drop != 0};
  endfunction

  function automatic logic [14:0] obs_vec();
    return {bus_if.dac_level, bus_if.powered, bus_if.tx_p, bus_if.tx_n, bus_if.rx_enable,
            bus_if.busy, bus_if.burst_done, bus_if.cmd_drop};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_cmds();
    bus_if.on = 0; bus_if.off = 0; bus_if.increase = 0; bus_if.decrease = 0;
    bus_if.send = 0; bus_if.receive = 0;
  endtask

  task automatic test_reset();
    rst = 1; bus_if.valid = 1; bus_if.amount = 8'd0; clear_cmds();
    tick(); tick();
    checks++;
    if (obs_vec() !== 15'd0) begin
      errors++; $display("FAIL reset_state: got %h expected 0", obs_vec());
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_model: got %h expected %h", obs_vec(), exp_vec());
    end
    rst = 0;
  endtask

  task automatic test_power_on();
    for (int i = 0; i < 22; i++) begin
      if (i == 0) begin bus_if.amount = 8'd10; bus_if.on = 1; end
      if (i == 5) bus_if.amount = 8'd77;
      if (i == 20) bus_if.on = 0;
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL power_on[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (i == 0) begin
        checks++;
        if (bus_if.powered !== 1'b1) begin
          errors++; $display("FAIL power_on_latency: got %b expected 1", bus_if.powered);
        end
      end
      if (i == 10 || i == 21) begin
        checks++;
        if (bus_if.dac_level !== 8'd10) begin
          errors++; $display("FAIL power_on_level[%0d]: got %0d expected 10", i, bus_if.dac_level);
        end
      end
    end
  endtask

  task automatic test_level_adjust();
    for (int i = 0; i < 516; i++) begin
      if (i == 0) begin bus_if.amount = 8'd250; bus_if.on = 1; end
      if (i == 1) bus_if.on = 0;
      if (i == 245) begin bus_if.amount = 8'd20; bus_if.increase = 1; end
      if (i == 246) bus_if.increase = 0;
      if (i == 255) begin bus_if.amount = 8'd255; bus_if.decrease = 1; end
      if (i == 256) bus_if.decrease = 0;
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL level[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (i == 250) begin
        checks++;
        if (bus_if.dac_level !== 8'd255) begin
          errors++; $display("FAIL level_saturate: got %0d expected 255", bus_if.dac_level);
        end
      end
      if (i == 515) begin
        checks++;
        if (bus_if.dac_level !== 8'd0) begin
          errors++; $display("FAIL level_floor: got %0d expected 0", bus_if.dac_level);
        end
      end
    end
    for (int i = 0; i < 400; i++) begin
      if (i % 40 == 0) begin
        bus_if.amount = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) bus_if.increase = 1; else bus_if.decrease = 1;
      end else begin
        bus_if.increase = 0; bus_if.decrease = 0;
      end
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL level_rand[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    clear_cmds();
  endtask

  task automatic test_burst_listen();
    int busy_cnt = 0, rx_cnt = 0, done_cnt = 0, done_idx = -1;
    for (int i = 0; i < 30; i++) begin
      if (i == 0) begin bus_if.send = 1; bus_if.receive = 1; end
      if (i == 1) begin bus_if.send = 0; bus_if.receive = 1'($urandom_range(0, 1)); end
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL listen[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (i < TXL) begin
        checks++;
        if (bus_if.tx_p !== ((i / 2) % 2 == 0) || bus_if.tx_n !== ((i / 2) % 2 == 1)) begin
          errors++; $display("FAIL tx_pattern[%0d]: got p=%b n=%b expected p=%b", i,
                              bus_if.tx_p, bus_if.tx_n, (i / 2) % 2 == 0);
        end
      end
      busy_cnt += int'(bus_if.busy);
      rx_cnt   += int'(bus_if.rx_enable);
      if (bus_if.burst_done === 1'b1) begin done_cnt++; done_idx = i; end
    end
    bus_if.receive = 0;
    checks++;
    if (busy_cnt != 21 || rx_cnt != 5 || done_cnt != 1 || done_idx != 21) begin
      errors++; $display("FAIL listen_timing: got busy=%0d rx=%0d done=%0d@%0d expected 21 5 1@21",
                          busy_cnt, rx_cnt, done_cnt, done_idx);
    end
  endtask

  task automatic test_back_to_back();
    int drop_cnt = 0, rx_cnt = 0, done_idx = -1;
    for (int i = 0; i < 25; i++) begin
      if (i == 0) begin bus_if.send = 1; bus_if.receive = 0; end
      if (i == 1) bus_if.send = 0;
      if (i == 4) begin bus_if.send = 1; bus_if.receive = 1; end
      if (i == 5) begin bus_if.send = 0; bus_if.receive = 0; end
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL b2b[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
      drop_cnt += int'(bus_if.cmd_drop);
      rx_cnt   += int'(bus_if.rx_enable);
      if (bus_if.burst_done === 1'b1) done_idx = i;
    end
    checks++;
    if (drop_cnt != 1 || rx_cnt != 0 || done_idx != 16) begin
      errors++; $display("FAIL b2b_timing: got drop=%0d rx=%0d done@%0d expected 1 0 16",
                          drop_cnt, rx_cnt, done_idx);
    end
  endtask

  task automatic test_off_mid_tx();
    int done_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) begin bus_if.send = 1; bus_if.receive = 1; end
      if (i == 1) bus_if.send = 0;
      if (i == 5) bus_if.off = 1;
      if (i == 6) bus_if.off = 0;
      if (i == 9) begin bus_if.amount = 8'($urandom_range(1, 255)); bus_if.increase = 1; end
      if (i == 10) bus_if.increase = 0;
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL off[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
      done_cnt += int'(bus_if.burst_done);
      if (i == 5) begin
        checks++;
        if ({bus_if.tx_p, bus_if.tx_n, bus_if.busy, bus_if.powered} !== 4'b0 || bus_if.dac_level !== 8'd0) begin
          errors++; $display("FAIL off_immediate: got p=%b n=%b busy=%b pow=%b dac=%0d expected all 0",
                              bus_if.tx_p, bus_if.tx_n, bus_if.busy, bus_if.powered, bus_if.dac_level);
        end
      end
      if (i == 9) begin
        checks++;
        if (bus_if.cmd_drop !== 1'b1) begin
          errors++; $display("FAIL unpowered_inc_drop: got %b expected 1", bus_if.cmd_drop);
        end
      end
    end
    bus_if.receive = 0;
    checks++;
    if (done_cnt != 0 || bus_if.dac_level !== 8'd0) begin
      errors++; $display("FAIL off_after: got done=%0d dac=%0d expected 0 0", done_cnt, bus_if.dac_level);
    end
  endtask

  task automatic test_valid_gate();
    for (int i = 0; i < 13; i++) begin
      if (i == 0) begin bus_if.valid = 0; bus_if.on = 1; bus_if.amount = 8'd33; end
      if (i == 3) bus_if.valid = 1;
      if (i == 7) bus_if.on = 0;
      if (i == 8) bus_if.on = 1;
      if (i == 9) bus_if.on = 0;
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL valid[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (i == 6 || i == 8) begin
        checks++;
        if (bus_if.powered !== (i == 8)) begin
          errors++; $display("FAIL valid_gate[%0d]: got %b expected %b", i, bus_if.powered, i == 8);
        end
      end
    end
  endtask

  task automatic test_reset_listen();
    int a = $urandom_range(5, 30);
    for (int i = 0; i < 61; i++) begin
      if (i == 0) begin bus_if.send = 1; bus_if.receive = 1; end
      if (i == 1) begin bus_if.send = 0; bus_if.receive = 0; end
      if (i == 17) rst = 1;
      if (i == 18) rst = 0;
      if (i == 20) begin bus_if.on = 1; bus_if.amount = 8'(a); end
      if (i == 21) bus_if.on = 0;
      if (i == 55) begin bus_if.increase = 1; bus_if.decrease = 1; bus_if.amount = 8'($urandom_range(1, 255)); end
      if (i == 56) begin bus_if.increase = 0; bus_if.decrease = 0; end
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL rst_listen[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (i == 16) begin
        checks++;
        if (bus_if.rx_enable !== 1'b1) begin
          errors++; $display("FAIL listen_entry: got %b expected 1", bus_if.rx_enable);
        end
      end
      if (i == 17) begin
        checks++;
        if (obs_vec() !== 15'd0) begin
          errors++; $display("FAIL rst_mid_burst: got %h expected 0", obs_vec());
        end
      end
      if (i == 55) begin
        checks++;
        if (bus_if.cmd_drop !== 1'b1) begin
          errors++; $display("FAIL incdec_drop: got %b expected 1", bus_if.cmd_drop);
        end
      end
    end
    checks++;
    if (bus_if.dac_level !== 8'(a)) begin
      errors++; $display("FAIL incdec_target: got %0d expected %0d", bus_if.dac_level, a);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) bus_if.on       = ~bus_if.on;
      if ($urandom_range(0, 31) == 0) bus_if.off     = ~bus_if.off;
      if ($urandom_range(0, 7) == 0) bus_if.increase = ~bus_if.increase;
      if ($urandom_range(0, 7) == 0) bus_if.decrease = ~bus_if.decrease;
      if ($urandom_range(0, 5) == 0) bus_if.send     = ~bus_if.send;
      bus_if.receive = 1'($urandom_range(0, 1));
      bus_if.valid   = ($urandom_range(0, 7) != 0);
      bus_if.amount  = 8'($urandom_range(0, 255));
      rst            = ($urandom_range(0, 199) == 0);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    rst = 0; clear_cmds(); bus_if.valid = 1;
  endtask

  initial begin
    rst = 1; bus_if.valid = 0; bus_if.amount = '0; clear_cmds();
    test_reset();
    test_power_on();
    test_level_adjust();
    test_burst_listen();
    test_back_to_back();
    test_off_mid_tx();
    test_valid_gate();
    test_reset_listen();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/us_tx_ctrl.md
# us_tx_ctrl

Downstream consumer of the command decoder in the ultrasonic system. Turns the decoder's held command levels into one-shot events and maintains a slew-limited transducer drive level for the DAC. On a send command it runs a transmit burst: complementary square-wave drive, then a blanking interval, then an optional echo-listen window. Outputs go to the DAC interface, the transducer driver pins and the receive front-end enable.

## Interface
- AMOUNT_WIDTH, 8: width of `amount`, `dac_level` and the internal target level.
- HALF_PERIOD, 1250: clock cycles per half period of the transmit tone (40 kHz at 100 MHz); ≥1.
- BURST_CYCLES, 8: full tone periods per burst; ≥1.
- BLANK_CYCLES, 2000: post-burst blanking length in clocks; ≥1.
- LISTEN_CYCLES, 200000: listen-window length in clocks; ≥1.
- RAMP_DIV, 16: clocks per one-LSB step of `dac_level`; ≥1.
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- on, off, increase, decrease, send, receive  in  1 each  decoder command levels; may be held for many cycles.
- valid  in  1  decoder valid; gates every command event.
- amount  in  AMOUNT_WIDTH  level operand from the decoder.
- dac_level  out  AMOUNT_WIDTH  ramped drive level to the DAC.
- powered  out  1  transmitter enabled.
- tx_p, tx_n  out  1 each  transducer drive; complementary during TX, both 0 otherwise.
- rx_enable  out  1  high only in LISTEN.
- busy  out  1  burst FSM not in IDLE.
- burst_done  out  1  one-cycle pulse on normal completion of a burst.
- cmd_drop  out  1  one-cycle pulse when a command event is rejected.

## Operation
- Edge detection: one previous-value register per command input, reset 0, updated every cycle regardless of `valid`. X_evt = X & ~X_prev & valid. A held level produces exactly one event.
- Power:
  - on_evt: powered←1, target←amount.
  - off_evt: powered←0, target←0, dac_level←0 immediately, burst FSM→IDLE with no burst_done.
  - on_evt and off_evt in the same cycle: off wins.
- Level adjust:
  - inc_evt: target←min(target+amount, 2^AMOUNT_WIDTH−1). Compute with one extra bit, then saturate.
  - dec_evt: target←max(target−amount, 0).
  - Accepted only while powered. Otherwise the event is ignored and cmd_drop pulses.
  - inc_evt and dec_evt in the same cycle: both ignored, cmd_drop pulses.
- Ramp:
  - Prescaler counts 0..RAMP_DIV−1 and wraps; it runs only while powered and is held at 0 otherwise.
  - When prescaler==RAMP_DIV−1 and dac_level≠target, dac_level moves 1 LSB toward target.
  - Ramping continues during a burst.
- Burst FSM states: IDLE, TX, BLANK, LISTEN.
  - IDLE→TX on send_evt while powered. rx_req←receive level sampled in the same cycle.
  - send_evt while unpowered or not IDLE: ignored, cmd_drop pulses.
  - TX: tx_p starts at 1 and toggles every HALF_PERIOD clocks; tx_n=~tx_p. After 2·BURST_CYCLES half periods →BLANK.
  - BLANK: lasts BLANK_CYCLES clocks, then →LISTEN if rx_req, else →IDLE with burst_done.
  - LISTEN: rx_enable=1 for LISTEN_CYCLES clocks, then →IDLE with burst_done.
- cmd_drop pulses once per cycle even if several events are rejected in that cycle.
- Reset: all outputs 0, FSM IDLE, target 0, prescaler 0, rx_req 0, all prev registers 0.

## Timing
- A command input that rises before edge k (with valid=1) has its effect visible after edge k: 1-cycle latency to powered, target, FSM state and tx_p.
- TX occupies exactly 2·BURST_CYCLES·HALF_PERIOD cycles. BLANK occupies exactly BLANK_CYCLES cycles. LISTEN occupies exactly LISTEN_CYCLES cycles.
- burst_done is high in the first IDLE cycle after BLANK (rx_req=0) or after LISTEN.
- Ramp from 0 to target T takes T·RAMP_DIV cycles after on_evt, with the prescaler starting from 0.
- Synchronous reset mid-burst: outputs are 0 at the next edge, no burst_done.
- valid low while a command rises, then valid goes high with the command still held: no event, because prev is already 1.

## Test plan
Parameters for all scenarios: HALF_PERIOD=2, BURST_CYCLES=3, BLANK=4, LISTEN=5, RAMP_DIV=1, AMOUNT_WIDTH=8.
- on with amount=10 and valid=1, held 20 cycles -> powered=1 one cycle later; dac_level reaches 10 after 10 cycles, then holds; exactly one event.
- Powered, target 250; increase with amount=20 -> target saturates at 255. Then decrease with amount=255 -> target 0. dac_level tracks at 1 LSB per clock.
- Powered; send with receive=1 -> tx_p pattern 1,1,0,0 repeated 3 times (12 cycles), tx_n its complement; 4 blank cycles; rx_enable high for 5 cycles; burst_done high for 1 cycle; busy high for 21 cycles.
- Send with receive=0, then a second send rising during TX -> no LISTEN, cmd_drop pulses once, burst_done 16 cycles after the first send.
- off rising mid-TX -> next cycle tx_p=tx_n=0, dac_level=0, busy=0, no burst_done. increase while unpowered -> cmd_drop, target unchanged.
- rst asserted during LISTEN with powered=1 -> all outputs 0 at the next edge. increase and decrease rising together -> cmd_drop, target unchanged.
